// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage iterative divider.
package div_unit_pkg;

  // Divider sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } divState_e;

  // Widest operand the divide-by-zero quotient constant covers
  localparam int unsigned DIV_MAX_WIDTH = 64;

  // Quotient delivered for a zero divisor (all ones, sliced to operand width)
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift {rem,quo} left by one and try subtracting the divisor from the partial remainder
  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[WIDTH]) begin
      remOut = shifted[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end else begin
      remOut = trial[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider serving DIV/DIVU; stalls the pipeline while iterating.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             div_stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  divState_e        state;
  divState_e        stateNext;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorReg;
  logic             negQ;
  logic             negR;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic             accept;
  logic             divByZero;
  logic             lastIter;
  logic [WIDTH-1:0] opaMag;
  logic [WIDTH-1:0] opbMag;
  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuo;

  // Operand acceptance and magnitude extraction for the signed case
  always_comb begin
    accept    = (state == IDLE) && start && !cancel;
    divByZero = (opb == '0);
    lastIter  = (counter == CNT_W'(1));
    opaMag    = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    opbMag    = (signed_div && opb[WIDTH-1]) ? -opb : opb;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .remIn  (remReg),
    .quoIn  (quoReg),
    .divisor(divisorReg),
    .remOut (stepRem),
    .quoOut (stepQuo)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; cancel always returns to IDLE and beats start
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          stateNext = divByZero ? DONE : DIV;
        end
      end
      DIV: begin
        if (cancel) begin
          stateNext = IDLE;
        end else if (lastIter) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, and sign-corrected result load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter    <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      negQ       <= 1'b0;
      negR       <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            remReg     <= '0;
            quoReg     <= opaMag;
            divisorReg <= opbMag;
            negQ       <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            negR       <= signed_div & opa[WIDTH-1];
            counter    <= CNT_W'(WIDTH);
            if (divByZero) begin
              loReg <= DIV_ZERO_QUO[WIDTH-1:0];
              hiReg <= opa;
            end
          end
        end
        DIV: begin
          if (!cancel) begin
            remReg  <= stepRem;
            quoReg  <= stepQuo;
            counter <= counter - CNT_W'(1);
            if (lastIter) begin
              loReg <= negQ ? -stepQuo : stepQuo;
              hiReg <= negR ? -stepRem : stepRem;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Stall is combinational so the hazard unit sees it in the accepting cycle
  assign div_stall = accept || (state == DIV);
  assign ready     = (state == DONE);
  assign hi_out    = hiReg;
  assign lo_out    = loReg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, multi-cycle corner sequences, random vs model.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic         cancel;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         div_stall;
  logic         ready;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    bit           hold;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .cancel    (cancel),
    .opa       (opa),
    .opb       (opb),
    .div_stall (div_stall),
    .ready     (ready),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural reference: truncating division, remainder follows dividend
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one divide at the current negedge (cycle 0) and check timing and results
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input int elat,
                       input bit hold);
    int seen;
    bit stallBad;
    opa = a; opb = b; signed_div = s; start = 1'b1; cancel = 1'b0;
    #1 chk("stall_accept", W'(div_stall), W'(1));
    seen = -1;
    stallBad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) begin
        seen = k;
        break;
      end
      if (!div_stall) stallBad = 1'b1;
      if (hold) begin
        start = 1'b1;
        opa = ~a;
        opb = b + W'(3);
        signed_div = ~s;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", W'(seen), W'(elat));
    chk("stall_during", W'(stallBad), W'(0));
    chk("stall_at_ready", W'(div_stall), W'(0));
    chk("lo_out", lo_out, eq);
    chk("hi_out", hi_out, er);
    @(negedge clk);
    chk("ready_pulse", W'(ready), W'(0));
    chk("stall_after", W'(div_stall), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rs;
    bit           sawReady;

    tbl[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         33, 1'b0};
    tbl[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  33, 1'b0};
    tbl[2] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         33, 1'b0};
    tbl[3] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         33, 1'b0};
    tbl[4] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  33, 1'b0};
    tbl[5] = '{32'h1234,      32'd0,         1'b0, 32'hFFFFFFFF,  32'h1234,      1,  1'b0};
    tbl[6] = '{32'hFFFFFF00,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFF00,  1,  1'b1};
    tbl[7] = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         33, 1'b0};
    tbl[8] = '{32'd5,         32'd9,         1'b1, 32'd0,         32'd5,         33, 1'b1};
    tbl[9] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF,  33, 1'b0};

    rst = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    #1;
    chk("rst_hi", hi_out, '0);
    chk("rst_lo", lo_out, '0);
    chk("rst_ready", W'(ready), W'(0));
    chk("rst_stall", W'(div_stall), W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back
    for (int i = 0; i < 10; i++) begin
      runOp(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].lat, tbl[i].hold);
    end

    // Cancel mid-divide: no ready, outputs unchanged, then a clean divide
    runOp(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33, 1'b0);
    opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) begin
        cancel = 1'b1;
        start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1 chk("cancel_idle_stall", W'(div_stall), W'(0));
    sawReady = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready || div_stall) sawReady = 1'b1;
    end
    chk("cancel_no_ready", W'(sawReady), W'(0));
    chk("cancel_lo_hold", lo_out, 32'd100);
    chk("cancel_hi_hold", hi_out, 32'd0);

    // Cancel beats start in IDLE
    opa = 32'd5; opb = 32'd0; start = 1'b1; cancel = 1'b1;
    #1 chk("cancel_wins_stall", W'(div_stall), W'(0));
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    sawReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ready || div_stall) sawReady = 1'b1;
      @(negedge clk);
    end
    chk("cancel_wins_idle", W'(sawReady), W'(0));
    chk("cancel_wins_lo", lo_out, 32'd100);
    runOp(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);

    // Asynchronous reset mid-divide
    opa = 32'd77; opb = 32'd3; signed_div = 1'b0; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_lo", lo_out, '0);
    chk("midrst_hi", hi_out, '0);
    chk("midrst_stall", W'(div_stall), W'(0));
    chk("midrst_ready", W'(ready), W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    runOp(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33, 1'b0);

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = -W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i == 7) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      refDiv(ra, rb, rs, rq, rr);
      runOp(ra, rb, rs, rq, rr, (rb == '0) ? 1 : 33, (i % 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
